// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller around the ID/EX register: load-use stall, redirect flush,
// registered ALU forwarding selects and halt drain. Define PIPE_PERF_CNT_EN for stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_rw,
  input  logic              id_regwrite,
  input  logic              id_load,
  input  logic              id_halt,
  input  logic              ex_redirect,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int unsigned FWD_W   = 2;
  localparam int unsigned DRAIN_W = 2;
  localparam logic [FWD_W-1:0]   FWD_RF      = 2'b00;
  localparam logic [FWD_W-1:0]   FWD_EXMEM   = 2'b01;
  localparam logic [FWD_W-1:0]   FWD_MEMWB   = 2'b10;
  localparam logic [DRAIN_W-1:0] DRAIN_START = 2'd2;

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} state_t;

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rw;
    logic              wr;
    logic              ld;
  } slot_t;

  state_t             state, state_n;
  logic [DRAIN_W-1:0] drain_cnt, drain_n;
  slot_t              ex_slot, mem_slot, wb_slot, ex_n;
  logic [FWD_W-1:0]   fwd_a_n, fwd_b_n;
  logic               hazard, redirect, halt_go, load_use, advance;
  logic               unused_wb;

  // A slot can supply r only if it really writes a non-zero register equal to r.
  function automatic logic src_hit(slot_t s, logic [REG_AW-1:0] r);
    return s.v && s.wr && (s.rw != '0) && (s.rw == r);
  endfunction

  // Nearest producer wins; a load in EX cannot forward from the ALU.
  function automatic logic [FWD_W-1:0] fwd_pick(logic used, logic [REG_AW-1:0] r,
                                                slot_t ex_s, slot_t mem_s);
    if (!used) return FWD_RF;
    if (src_hit(ex_s, r) && !ex_s.ld) return FWD_EXMEM;
    if (src_hit(mem_s, r)) return FWD_MEMWB;
    return FWD_RF;
  endfunction

  assign hazard = id_valid && ex_slot.ld &&
                  ((id_use_rs && src_hit(ex_slot, id_rs)) ||
                   (id_use_rt && src_hit(ex_slot, id_rt)));

  // WB slot only matters for drain completion; its other fields just retire.
  assign unused_wb = ^{wb_slot.rw, wb_slot.wr, wb_slot.ld};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      drain_cnt <= '0;
      ex_slot   <= '0;
      mem_slot  <= '0;
      wb_slot   <= '0;
      fwd_a     <= FWD_RF;
      fwd_b     <= FWD_RF;
      halted    <= 1'b0;
    end else begin
      state     <= state_n;
      drain_cnt <= drain_n;
      ex_slot   <= ex_n;
      mem_slot  <= ex_slot;
      wb_slot   <= mem_slot;
      fwd_a     <= fwd_a_n;
      fwd_b     <= fwd_b_n;
      halted    <= (state_n == HALTED);
    end
  end

  always_comb begin
    state_n    = state;
    drain_n    = drain_cnt;
    redirect   = 1'b0;
    halt_go    = 1'b0;
    load_use   = 1'b0;
    advance    = 1'b0;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b1;
    ex_n       = '0;
    fwd_a_n    = FWD_RF;
    fwd_b_n    = FWD_RF;

    unique case (state)
      RUN: begin
        // Redirect outranks halt and load-use; halt outranks load-use.
        redirect   = ex_redirect;
        halt_go    = !ex_redirect && id_valid && id_halt;
        load_use   = !ex_redirect && !halt_go && hazard;
        advance    = !(redirect || halt_go || load_use);
        pc_en      = !(halt_go || load_use);
        ifid_en    = !(halt_go || load_use);
        ifid_flush = redirect;
        idex_flush = !advance;
        if (halt_go) begin
          state_n = DRAIN;
          drain_n = DRAIN_START;
        end
      end
      DRAIN: begin
        if ((drain_cnt == '0) && !mem_slot.v && !wb_slot.v) begin
          state_n = HALTED;
        end else if (drain_cnt != '0) begin
          drain_n = drain_cnt - DRAIN_W'(1);
        end
      end
      HALTED: begin
        state_n = HALTED;
      end
      default: begin
        state_n = RUN;
      end
    endcase

    if (advance) begin
      ex_n = '{v: id_valid, rw: id_rw, wr: id_regwrite, ld: id_load};
      if (id_valid) begin
        fwd_a_n = fwd_pick(id_use_rs, id_rs, ex_slot, mem_slot);
        fwd_b_n = fwd_pick(id_use_rt, id_rt, ex_slot, mem_slot);
      end
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  // Counters only move in RUN, so they hold still once halted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_q + CNT_W'(load_use);
      flush_q <= flush_q + CNT_W'(redirect);
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: stimulus pushes expected per-cycle outputs from an
// instruction-level reference model; a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 32;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_use_rs, id_use_rt, id_regwrite, id_load, id_halt, ex_redirect;
  logic [REG_AW-1:0] id_rs, id_rt, id_rw;
  logic pc_en, ifid_en, ifid_flush, idex_flush, halted;
  logic [1:0] fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rw(id_rw), .id_regwrite(id_regwrite),
    .id_load(id_load), .id_halt(id_halt), .ex_redirect(ex_redirect), .pc_en(pc_en),
    .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush), .fwd_a(fwd_a),
    .fwd_b(fwd_b), .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v; int rs; int rt; bit urs; bit urt; int rw; bit wr; bit ld; bit hlt;
  } ins_t;

  typedef struct { bit v; int rw; bit wr; bit ld; } minst_t;

  typedef struct {
    bit pc_en; bit ifid_en; bit ifid_flush; bit idex_flush;
    int fwd_a; int fwd_b; bit halted; longint stall; longint flush;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int total = 0;
  int bad = 0;

  // Reference model: in-flight instructions by age (0 = in EX), run/drain/halted mode.
  minst_t pipe_m[3];
  int mode;          // 0 run, 1 drain, 2 halted
  int drain_left;
  int m_fwd_a, m_fwd_b;
  int unsigned m_stall, m_flush;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe_m[i] = '{v: 0, rw: 0, wr: 0, ld: 0};
    mode = 0; drain_left = 0; m_fwd_a = 0; m_fwd_b = 0; m_stall = 0; m_flush = 0;
  endtask

  function automatic int src_of(bit used, int r);
    if (!used || r == 0) return 0;
    if (pipe_m[0].v && pipe_m[0].wr && pipe_m[0].rw == r && !pipe_m[0].ld) return 1;
    if (pipe_m[1].v && pipe_m[1].wr && pipe_m[1].rw == r) return 2;
    return 0;
  endfunction

  function automatic bit pend_load(ins_t in);
    if (!(pipe_m[0].v && pipe_m[0].wr && pipe_m[0].ld && pipe_m[0].rw != 0)) return 0;
    return (in.urs && in.rs == pipe_m[0].rw) || (in.urt && in.rt == pipe_m[0].rw);
  endfunction

  task automatic chk(input string name, input longint act, input longint want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, want, $time);
    end
  endtask

  // One clock of stimulus; r_late asserts reset mid-cycle (async) instead of at the drive point.
  task automatic step(input ins_t in, input bit redir, input bit r, input bit r_late,
                      output bit consumed);
    exp_t e;
    bit redirect_m, halt_m, lu_m, adv_m;
    int na, nb;
    @(posedge clk); #1;
    id_valid = in.v; id_rs = REG_AW'(in.rs); id_rt = REG_AW'(in.rt);
    id_use_rs = in.urs; id_use_rt = in.urt; id_rw = REG_AW'(in.rw);
    id_regwrite = in.wr; id_load = in.ld; id_halt = in.hlt; ex_redirect = redir;
    if (r_late) begin #1; rst = r; end
    else rst = r;
    if (rst) model_reset();

    redirect_m = (mode == 0) && redir;
    halt_m     = (mode == 0) && !redir && in.v && in.hlt;
    lu_m       = (mode == 0) && !redir && !halt_m && in.v && pend_load(in);
    adv_m      = (mode == 0) && !redirect_m && !halt_m && !lu_m;

    e.pc_en      = (mode == 0) && !halt_m && !lu_m;
    e.ifid_en    = e.pc_en;
    e.ifid_flush = redirect_m;
    e.idex_flush = !adv_m;
    e.fwd_a      = m_fwd_a;
    e.fwd_b      = m_fwd_b;
    e.halted     = (mode == 2);
`ifdef PIPE_PERF_CNT_EN
    e.stall = m_stall;
    e.flush = m_flush;
`else
    e.stall = 0;
    e.flush = 0;
`endif
    exp_q.push_back(e);
    consumed = rst || !lu_m;

    if (!rst) begin
      na = (adv_m && in.v) ? src_of(in.urs, in.rs) : 0;
      nb = (adv_m && in.v) ? src_of(in.urt, in.rt) : 0;
      if (redirect_m) m_flush++;
      if (lu_m) m_stall++;
      if (halt_m) begin
        mode = 1; drain_left = 3;
      end else if (mode == 1) begin
        drain_left--;
        if (drain_left == 0) mode = 2;
      end
      pipe_m[2] = pipe_m[1];
      pipe_m[1] = pipe_m[0];
      if (adv_m) pipe_m[0] = '{v: in.v, rw: in.rw, wr: in.wr, ld: in.ld};
      else       pipe_m[0] = '{v: 0, rw: 0, wr: 0, ld: 0};
      m_fwd_a = na; m_fwd_b = nb;
    end
  endtask

  function automatic ins_t mk(int rs, int rt, bit urs, bit urt, int rw, bit wr, bit ld);
    ins_t i;
    i = '{v: 1, rs: rs, rt: rt, urs: urs, urt: urt, rw: rw, wr: wr, ld: ld, hlt: 0};
    return i;
  endfunction

  function automatic ins_t nop();
    ins_t i;
    i = '{v: 0, rs: 0, rt: 0, urs: 0, urt: 0, rw: 0, wr: 0, ld: 0, hlt: 0};
    return i;
  endfunction

  // Front end holds the instruction in ID while stalled.
  task automatic issue(input ins_t in, input bit redir);
    bit ok;
    ok = 0;
    for (int t = 0; t < 4 && !ok; t++) step(in, redir, 1'b0, 1'b0, ok);
    if (!ok) chk("stall_bound", 0, 1);
  endtask

  task automatic idle(input int n);
    bit ok;
    for (int k = 0; k < n; k++) step(nop(), 1'b0, 1'b0, 1'b0, ok);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("pc_en", pc_en, mon_e.pc_en);
        chk("ifid_en", ifid_en, mon_e.ifid_en);
        chk("ifid_flush", ifid_flush, mon_e.ifid_flush);
        chk("idex_flush", idex_flush, mon_e.idex_flush);
        chk("fwd_a", fwd_a, mon_e.fwd_a);
        chk("fwd_b", fwd_b, mon_e.fwd_b);
        chk("halted", halted, mon_e.halted);
        chk("stall_cnt", stall_cnt, mon_e.stall);
        chk("flush_cnt", flush_cnt, mon_e.flush);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ins_t hlt_i, ri;
    bit ok;
    rst = 1'b1;
    id_valid = 0; id_rs = '0; id_rt = '0; id_use_rs = 0; id_use_rt = 0; id_rw = '0;
    id_regwrite = 0; id_load = 0; id_halt = 0; ex_redirect = 0;
    model_reset();
    for (int k = 0; k < 2; k++) step(nop(), 1'b0, 1'b1, 1'b0, ok);
    idle(2);

    // lw $3 then dependent add $4,$3,$3
    issue(mk(0, 3, 1, 0, 3, 1, 1), 0);
    issue(mk(3, 3, 1, 1, 4, 1, 0), 0);
    idle(3);
    // add $5,$1,$2 ; sub $6,$5,$7
    issue(mk(1, 2, 1, 1, 5, 1, 0), 0);
    issue(mk(5, 7, 1, 1, 6, 1, 0), 0);
    idle(3);
    // add $5 ; or $8 ; and $9,$5,$5 ; then same with $0 destination
    issue(mk(1, 2, 1, 1, 5, 1, 0), 0);
    issue(mk(1, 2, 1, 1, 8, 1, 0), 0);
    issue(mk(5, 5, 1, 1, 9, 1, 0), 0);
    idle(2);
    issue(mk(1, 2, 1, 1, 0, 1, 0), 0);
    issue(mk(1, 2, 1, 1, 8, 1, 0), 0);
    issue(mk(0, 0, 1, 1, 9, 1, 0), 0);
    issue(mk(0, 3, 1, 0, 0, 1, 1), 0);
    issue(mk(0, 0, 1, 1, 4, 1, 0), 0);
    idle(2);
    // lw $3 then dependent instruction arriving with a taken branch in EX
    issue(mk(0, 3, 1, 0, 3, 1, 1), 0);
    issue(mk(3, 3, 1, 1, 4, 1, 0), 1);
    idle(3);

    // Random traffic over a tiny register set to force many matches
    for (int n = 0; n < 300; n++) begin
      ri = mk($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
              $urandom_range(0, 3), ($urandom % 5) != 0, ($urandom % 3) == 0);
      ri.v = ($urandom % 8) != 0;
      issue(ri, ($urandom % 8) == 0);
    end
    idle(3);

    // Halt, redirect ignored while draining, reset in the middle of the drain
    hlt_i = nop(); hlt_i.v = 1; hlt_i.hlt = 1;
    issue(mk(1, 2, 1, 1, 5, 1, 0), 0);
    issue(hlt_i, 0);
    step(nop(), 1'b1, 1'b0, 1'b0, ok);
    step(nop(), 1'b0, 1'b1, 1'b1, ok);
    step(nop(), 1'b0, 1'b0, 1'b0, ok);
    issue(mk(0, 3, 1, 0, 3, 1, 1), 0);
    issue(mk(3, 3, 1, 1, 4, 1, 0), 0);
    // Full drain into HALTED, redirects there must not count
    issue(hlt_i, 0);
    idle(3);
    step(nop(), 1'b1, 1'b0, 1'b0, ok);
    idle(2);
    step(hlt_i, 1'b1, 1'b0, 1'b0, ok);
    // Asynchronous reset between edges while halted
    step(nop(), 1'b0, 1'b1, 1'b1, ok);
    step(nop(), 1'b0, 1'b0, 1'b0, ok);
    issue(mk(1, 2, 1, 1, 5, 1, 0), 0);
    issue(mk(5, 5, 1, 1, 6, 1, 0), 0);
    idle(2);

    @(negedge clk); #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
